scroll_step_ctrl: RTL and testbench
===================================

# scroll_step_ctrl

Generates the step strobes for the message-scroll stage that drives the four-digit LED display. Produces `m_tick`, a periodic auto-scroll pulse from a clock prescaler, and `button`, a clean single-cycle pulse from a synchronised, debounced push-button. Both outputs connect directly to the scroll stage's step inputs. The scroll stage advances one digit position per pulse.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per auto-scroll step (≥2).
- `DEBOUNCE_CYCLES`, default 500_000: consecutive stable cycles needed to accept a level change (≥1).
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `reset` input, 1 bit: reset, synchronous, active-high.
- `button_raw` input, 1 bit: raw push-button level; asynchronous and bouncy; active-high.
- `run_en` input, 1 bit: enables auto-scroll (slide switch); quasi-static level.
- `m_tick` output, 1 bit: one-cycle auto-scroll pulse.
- `button` output, 1 bit: one-cycle manual-step pulse, one per accepted press.

## Operation
- Synchroniser:
  - Two flip-flops, `s1 <= button_raw`, `s2 <= s1`.
  - Only `s2` is used downstream.
- Debounce FSM states: IDLE (stable 0), ARMING (s2=1, counting), HELD (stable 1), RELEASING (s2=0, counting).
  - IDLE:
    - If `s2=1`, go to ARMING with `dcnt=1`.
  - ARMING:
    - If `s2=0`, go to IDLE with `dcnt=0`.
    - Otherwise, if `dcnt==DEBOUNCE_CYCLES`, go to HELD and assert `button` for exactly that one cycle.
    - Otherwise, increment `dcnt`.
  - HELD:
    - If `s2=0`, go to RELEASING with `dcnt=1`.
  - RELEASING:
    - If `s2=1`, go to HELD with `dcnt=0`.
    - Otherwise, if `dcnt==DEBOUNCE_CYCLES`, go to IDLE; no pulse on release.
    - Otherwise, increment `dcnt`.
  - `dcnt` width is $clog2(DEBOUNCE_CYCLES+1). It never exceeds DEBOUNCE_CYCLES.
- Tick prescaler:
  - `tcnt` width is $clog2(TICK_DIV).
  - While `run_en=0`: `tcnt` is held at 0 and `m_tick` is 0.
  - While `run_en=1`: `tcnt` increments. When `tcnt==TICK_DIV-1`, `tcnt` wraps to 0 and `m_tick=1` for that cycle.
- Interaction:
  - A `button` pulse clears `tcnt` to 0 in the same cycle. A manual step is therefore never followed by an auto step sooner than TICK_DIV cycles later.
  - If a button pulse and a tick would occur in the same cycle, only `button` is asserted and `tcnt` is cleared. The two outputs are never high together.

## Timing
- Reset values:
  - `m_tick=0`, `button=0`.
  - `s1=s2=0`, FSM=IDLE, `dcnt=0`, `tcnt=0`.
- Reset mid-operation:
  - Aborts any count.
  - A button held through reset deasserts and is re-debounced from IDLE. It yields a pulse DEBOUNCE_CYCLES+3 cycles after the first edge with reset low.
- `m_tick` and `button` are registered outputs, glitch-free, high for exactly 1 cycle.
- Press latency:
  - Let edge E be the first rising edge at which `button_raw=1` is sampled, with `button_raw` held high afterwards.
  - `button` is high in the cycle following edge E+DEBOUNCE_CYCLES+2.
  - A bounce of fewer than DEBOUNCE_CYCLES cycles produces no pulse.
- Tick period:
  - The first `m_tick` occurs TICK_DIV cycles after the first edge with `run_en=1`.
  - Subsequent ticks are exactly TICK_DIV cycles apart.
  - Deasserting `run_en` cancels a pending tick and restarts the count from 0.
- A held button produces exactly one pulse. There is no auto-repeat.

## Test plan
- Reset and basic tick (TICK_DIV=8):
  - Stimulus: hold `reset` 3 cycles, then `run_en=1`.
  - Required: both outputs are 0 during reset; `m_tick` pulses at cycles 8, 16, 24 after `run_en` rises; each pulse is 1 cycle wide.
- Clean press (DEBOUNCE_CYCLES=4):
  - Stimulus: `button_raw` goes 0→1 and is held 20 cycles.
  - Required: exactly one `button` pulse, 7 cycles after the sampling edge (E+6 edge, high in the next cycle); no pulse on release.
- Bounce rejection:
  - Stimulus: toggle `button_raw` 1,0,1,0 each 2 cycles, then hold 1.
  - Required: exactly one pulse, 7 cycles after the final rising sample.
- Collision:
  - Stimulus: TICK_DIV=8, `run_en=1`; align the press so that `button` would fire at `tcnt==7`.
  - Required: `button=1`, `m_tick=0` that cycle; next `m_tick` 8 cycles later.
- `run_en` toggle:
  - Stimulus: drop `run_en` at `tcnt=5` for 3 cycles, then raise it.
  - Required: no tick during the gap; next tick 8 cycles after re-enable.
- Reset mid-press:
  - Stimulus: assert `reset` while ARMING with `dcnt=3`, hold `button_raw=1`.
  - Required: no pulse during reset; one pulse DEBOUNCE_CYCLES+3 cycles after reset release.

Source files
------------

// File: rtl/scroll_step_ctrl.sv
// Step-strobe generator for the LED message scroller: periodic auto-scroll tick
// plus a synchronised, debounced single-cycle manual-step pulse.
module scroll_step_ctrl #(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    input  logic run_en,
    output logic m_tick,
    output logic button
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TICK_DIV);

    localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DCNT_ONE = DW'(1);
    localparam logic [TW-1:0] TCNT_MAX = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TCNT_ONE = TW'(1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ARMING    = 2'd1;
    localparam logic [1:0] HELD      = 2'd2;
    localparam logic [1:0] RELEASING = 2'd3;

    logic          s1;
    logic          s2;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_nxt;
    logic          press;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nxt;
    logic          tick_nxt;

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES stable samples.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        press     = 1'b0;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_nxt = ARMING;
                    dcnt_nxt  = DCNT_ONE;
                end else begin
                    dcnt_nxt  = '0;
                end
            end
            ARMING: begin
                if (!s2) begin
                    state_nxt = IDLE;
                    dcnt_nxt  = '0;
                end else if (dcnt == DCNT_MAX) begin
                    state_nxt = HELD;
                    dcnt_nxt  = '0;
                    press     = 1'b1;
                end else begin
                    dcnt_nxt  = dcnt + DCNT_ONE;
                end
            end
            HELD: begin
                if (!s2) begin
                    state_nxt = RELEASING;
                    dcnt_nxt  = DCNT_ONE;
                end else begin
                    dcnt_nxt  = '0;
                end
            end
            RELEASING: begin
                if (s2) begin
                    state_nxt = HELD;
                    dcnt_nxt  = '0;
                end else if (dcnt == DCNT_MAX) begin
                    state_nxt = IDLE;
                    dcnt_nxt  = '0;
                end else begin
                    dcnt_nxt  = dcnt + DCNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                dcnt_nxt  = '0;
            end
        endcase
    end

    // A manual step restarts the prescaler and suppresses a coincident tick.
    always_comb begin
        tcnt_nxt = tcnt;
        tick_nxt = 1'b0;
        if (press || !run_en) begin
            tcnt_nxt = '0;
        end else if (tcnt == TCNT_MAX) begin
            tcnt_nxt = '0;
            tick_nxt = 1'b1;
        end else begin
            tcnt_nxt = tcnt + TCNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            state  <= IDLE;
            dcnt   <= '0;
            tcnt   <= '0;
            m_tick <= 1'b0;
            button <= 1'b0;
        end else begin
            s1     <= button_raw;
            s2     <= s1;
            state  <= state_nxt;
            dcnt   <= dcnt_nxt;
            tcnt   <= tcnt_nxt;
            m_tick <= tick_nxt;
            button <= press;
        end
    end

endmodule

// File: tb/tb_scroll_step_ctrl.sv
// Directed bench for scroll_step_ctrl with TICK_DIV=8, DEBOUNCE_CYCLES=4.
module tb_scroll_step_ctrl;

    localparam int TICK_DIV        = 8;
    localparam int DEBOUNCE_CYCLES = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic button_raw = 1'b0;
    logic run_en = 1'b0;
    logic m_tick;
    logic button;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic rst;
        logic braw;
        logic run;
        logic exp_tick;
        logic exp_btn;
    } vec_t;

    vec_t vecs[$];

    scroll_step_ctrl #(
        .TICK_DIV(TICK_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .button_raw(button_raw),
        .run_en(run_en),
        .m_tick(m_tick),
        .button(button)
    );

    always #5 clk = ~clk;

    task automatic add(input int n, input logic r, input logic b, input logic e,
                       input logic t, input logic bt);
        for (int i = 0; i < n; i++) vecs.push_back('{r, b, e, t, bt});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic exp_t, input logic exp_b);
        vectors++;
        if (m_tick !== exp_t || button !== exp_b) begin
            errors++;
            $display("FAIL %s: m_tick=%b button=%b, expected m_tick=%b button=%b",
                     name, m_tick, button, exp_t, exp_b);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        int n;

        // Reset then free-running ticks at steps 8, 16, 24
        add(3, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            add(7, 0, 0, 1, 0, 0);
            add(1, 0, 0, 1, 1, 0);
        end
        add(2, 0, 0, 0, 0, 0);

        // Clean press held 20 cycles: one pulse on step 7, none on release
        add(6, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1);
        add(13, 0, 1, 0, 0, 0);
        add(12, 0, 0, 0, 0, 0);

        // Bounce 1,0,1,0 (2 cycles each) then hold: pulse 7 steps after final rise
        add(2, 0, 1, 0, 0, 0);
        add(2, 0, 0, 0, 0, 0);
        add(2, 0, 1, 0, 0, 0);
        add(2, 0, 0, 0, 0, 0);
        add(6, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1);
        add(5, 0, 1, 0, 0, 0);
        add(12, 0, 0, 0, 0, 0);

        // Collision: press lands on the tcnt==7 edge; button wins, tick 8 later
        add(1, 0, 0, 1, 0, 0);
        add(6, 0, 1, 1, 0, 0);
        add(1, 0, 1, 1, 0, 1);
        add(7, 0, 1, 1, 0, 0);
        add(1, 0, 1, 1, 1, 0);
        add(12, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset      = vecs[i].rst;
            button_raw = vecs[i].braw;
            run_en     = vecs[i].run;
            step();
            check($sformatf("vec%0d", i), vecs[i].exp_tick, vecs[i].exp_btn);
        end

        // run_en dropped at tcnt=5 for 3 cycles
        reset = 1'b0;
        button_raw = 1'b0;
        run_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("toggle_pre", 1'b0, 1'b0);
        end
        run_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("toggle_gap", 1'b0, 1'b0);
        end
        run_en = 1'b1;
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            step();
            if (m_tick) n = i;
        end
        check_int("toggle_latency", n, TICK_DIV);
        step();
        check("toggle_width", 1'b0, 1'b0);
        run_en = 1'b0;
        step();

        // Reset while ARMING with dcnt=3, button held throughout
        button_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_arm", 1'b0, 1'b0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_hold", 1'b0, 1'b0);
        end
        reset = 1'b0;
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            step();
            if (button) n = i;
        end
        check_int("rst_press_latency", n, DEBOUNCE_CYCLES + 3);
        step();
        check("rst_press_width", 1'b0, 1'b0);
        button_raw = 1'b0;
        for (int i = 0; i < 10; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
